// File: rtl/pwm_sequencer.sv
// pwm_sequencer: run/stop and configuration controller for one PWM channel.
// Owns the period counter and the duty compare. New period/duty pairs are
// accepted over a valid/ready handshake. They take effect only at period
// boundaries, so the output never glitches. On stop, the current period is
// finished before the block idles.
//
// Ports:
//   MClk        system clock, rising edge
//   Reset_n     asynchronous active-low reset
//   Run         level: 1 = generate PWM, 0 = stop at end of current period
//   CfgValid    config word offered
//   CfgReady    config word can be accepted (low while a pending word waits)
//   CfgPeriod   period minus one
//   CfgDuty     high cycles per period
//   PwmOut      registered PWM output
//   PeriodStart pulse on the first cycle (Count==0) of every period
//   Busy        high while running or draining
module pwm_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             MClk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             CfgValid,
    output logic             CfgReady,
    input  logic [WIDTH-1:0] CfgPeriod,
    input  logic [WIDTH-1:0] CfgDuty,
    output logic             PwmOut,
    output logic             PeriodStart,
    output logic             Busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] act_period_q, act_period_d;
    logic [WIDTH-1:0] act_duty_q, act_duty_d;
    logic [WIDTH-1:0] pend_period_q, pend_period_d;
    logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
    logic             loaded_q, loaded_d;
    logic             pend_full_q, pend_full_d;
    logic             pwm_q, pwm_d;

    logic xfer;
    logic active;
    logic boundary;

    assign xfer     = CfgValid & ~pend_full_q;
    assign active   = (state_q != StIdle);
    assign boundary = active & (count_q == act_period_q);

    // State register
    always_ff @(posedge MClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Stop requests are honoured only on the boundary cycle,
    // so the period in flight always completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (Run && (loaded_q || xfer)) begin
                    state_d = StRun;
                end
            end
            StRun, StDrain: begin
                if (Run) begin
                    state_d = StRun;
                end else if (boundary) begin
                    state_d = StIdle;
                end else begin
                    state_d = StDrain;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counter and configuration next-state
    always_comb begin
        count_d       = '0;
        act_period_d  = act_period_q;
        act_duty_d    = act_duty_q;
        pend_period_d = pend_period_q;
        pend_duty_d   = pend_duty_q;
        loaded_d      = loaded_q;
        pend_full_d   = pend_full_q;

        if (!active) begin
            // Idle: config goes straight to the active set
            if (xfer) begin
                act_period_d = CfgPeriod;
                act_duty_d   = CfgDuty;
                loaded_d     = 1'b1;
            end
        end else if (boundary) begin
            // Pending takes priority; xfer cannot happen while it is full
            if (pend_full_q) begin
                act_period_d = pend_period_q;
                act_duty_d   = pend_duty_q;
                pend_full_d  = 1'b0;
            end else if (xfer) begin
                act_period_d = CfgPeriod;
                act_duty_d   = CfgDuty;
            end
        end else begin
            count_d = count_q + One;
            if (xfer) begin
                pend_period_d = CfgPeriod;
                pend_duty_d   = CfgDuty;
                pend_full_d   = 1'b1;
            end
        end
    end

    // Compare against the values that will govern the next cycle so PwmOut
    // lines up with Count, including the first cycle after a config swap.
    always_comb begin
        pwm_d = (state_d != StIdle) && (count_d < act_duty_d);
    end

    always_ff @(posedge MClk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q       <= '0;
            act_period_q  <= '0;
            act_duty_q    <= '0;
            pend_period_q <= '0;
            pend_duty_q   <= '0;
            loaded_q      <= 1'b0;
            pend_full_q   <= 1'b0;
            pwm_q         <= 1'b0;
        end else begin
            count_q       <= count_d;
            act_period_q  <= act_period_d;
            act_duty_q    <= act_duty_d;
            pend_period_q <= pend_period_d;
            pend_duty_q   <= pend_duty_d;
            loaded_q      <= loaded_d;
            pend_full_q   <= pend_full_d;
            pwm_q         <= pwm_d;
        end
    end

    // Outputs
    always_comb begin
        PwmOut      = pwm_q;
        PeriodStart = active && (count_q == '0);
        Busy        = active;
        CfgReady    = ~pend_full_q;
    end

endmodule
